imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 8, sets the instruction-memory word-address width; capacity is 2**ADDR_W words.
REQ-002 clk  input  1  single system clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-004 load_start  input  1  single-cycle request to begin a program load.
REQ-005 byte_valid  input  1  upstream byte stream valid.
REQ-006 byte_data  input  8  upstream byte payload.
REQ-007 byte_ready  output  1  loader accepts a byte this cycle.
REQ-008 imem_we  output  1  instruction-memory write strobe.
REQ-009 imem_waddr  output  ADDR_W  instruction-memory word address.
REQ-010 imem_wdata  output  32  instruction word to write.
REQ-011 core_rst_n  output  1  active-low reset to the riscv core; registered.
REQ-012 busy, done, err  output  1 each  status flags.

Function
REQ-013 A byte transfer occurs on a posedge where byte_valid and byte_ready are both 1; no other byte is consumed.
REQ-014 Stream format: 2-byte little-endian header N (word count), then 4*N payload bytes; each word is little-endian, so the first byte goes to [7:0] and the fourth to [31:24].
REQ-015 FSM states: IDLE, HDR0, HDR1, DATA, WRITE, DONE, ERR.
REQ-016 In IDLE, load_start=1 moves to HDR0; core_rst_n goes to 0 on the same edge.
REQ-017 In HDR0, a transfer latches N[7:0] and moves to HDR1.
REQ-018 In HDR1, a transfer latches N[15:8], clears the word index and byte counter, then:
- N==0: go to DONE.
- N>2**ADDR_W: go to ERR.
- Otherwise: go to DATA.
REQ-019 In DATA, each transfer shifts the byte into the word assembly register; after the 4th byte the FSM moves to WRITE.
REQ-020 In WRITE, for exactly one cycle: imem_we=1, imem_waddr=word index, imem_wdata=assembled word. The index then increments; if index+1==N go to DONE, else go to DATA.
REQ-021 byte_ready=1 only in HDR0, HDR1 and DATA; it is 0 in IDLE, WRITE, DONE and ERR, so a byte presented during WRITE is held upstream and not lost.
REQ-022 Byte-to-write latency: imem_we asserts the cycle after the transfer of a word's 4th byte.
REQ-023 busy=1 in HDR0, HDR1, DATA and WRITE; load_start while busy is ignored.
REQ-024 In DONE: done=1, core_rst_n=1, no writes; load_start returns to HDR0 and core_rst_n drops to 0 on that edge.
REQ-025 In ERR: err=1, core_rst_n=0, no writes; only load_start (to HDR0) or rst_n leaves ERR.
REQ-026 done and err clear on the edge that enters HDR0.
REQ-027 The word index is ADDR_W+1 bits wide, so a full-capacity load (N==2**ADDR_W) finishes without wrapping; imem_waddr is its low ADDR_W bits.
REQ-028 imem_waddr and imem_wdata hold their last values when imem_we=0.

Reset
REQ-029 With rst_n=0 at a posedge, the block forces: state IDLE, byte_ready 0, imem_we 0, imem_waddr 0, imem_wdata 0, core_rst_n 0, busy 0, done 0, err 0, N 0, index 0, byte counter 0.
REQ-030 Reset mid-load abandons the load immediately: no further imem_we, and partial words are discarded.

Verification
REQ-031 Two-word load, ADDR_W=8: load_start, then bytes 02 00 13 00 10 00 93 01 50 00 -> writes addr0=0x00100013, then addr1=0x00500193; done=1; core_rst_n=1 one cycle after the second write.
REQ-032 Header 00 00 -> DONE right after HDR1, zero imem_we pulses, core_rst_n=1.
REQ-033 Header 01 01 (N=257) with ADDR_W=8 -> ERR, err=1, core_rst_n=0, no writes, payload bytes not accepted.
REQ-034 Stream with byte_valid gaps, plus a valid byte held during WRITE -> byte_ready=0 in WRITE, the byte is consumed only in DATA, and the resulting words are correct.
REQ-035 rst_n=0 after 6 payload bytes -> all outputs at reset values next cycle; a fresh 1-word load then writes addr0 correctly.
REQ-036 load_start in DONE -> core_rst_n=0 and done=0 on the next edge; a new 1-word load overwrites addr0.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader
// Boot-time program loader. Receives a byte stream (16-bit little-endian
// word count N, then 4*N payload bytes, each word little-endian), writes the
// assembled 32-bit words to instruction memory at consecutive addresses from
// 0, and holds the core in reset until the whole program is in place.
//
// Ports:
//   clk, rst_n      system clock, synchronous active-low reset
//   load_start      one-cycle request to start a load (ignored while busy)
//   byte_valid/_data/_ready   upstream byte stream handshake
//   imem_we/_waddr/_wdata     instruction-memory write port
//   core_rst_n      active-low core reset, released only after a good load
//   busy, done, err status flags
//
// state  | meaning
// IDLE   | after reset, waiting for load_start
// HDR0   | waiting for word-count low byte
// HDR1   | waiting for word-count high byte
// DATA   | collecting the 4 bytes of the current word
// WRITE  | one-cycle imem write of the assembled word
// DONE   | load complete, core released
// ERR    | word count exceeds memory capacity, core held in reset
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    // Memory capacity in words, widened so it compares cleanly against N.
    localparam logic [16:0] CAP = 17'(1) << ADDR_W;

    state_t            state_q;
    logic [15:0]       n_q;
    logic [ADDR_W:0]   idx_q;      // one extra bit so a full-capacity load never wraps
    logic [1:0]        bcnt_q;
    logic [23:0]       asm_q;      // first three bytes of the word in flight
    logic              ready_q;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;
    logic              core_rst_n_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic              xfer;
    logic [15:0]       n_d;
    logic [31:0]       word_d;
    logic [ADDR_W:0]   idx_d;

    assign xfer   = byte_valid & ready_q;
    assign n_d    = {byte_data, n_q[7:0]};
    assign word_d = {byte_data, asm_q};
    assign idx_d  = idx_q + {{ADDR_W{1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            n_q          <= '0;
            idx_q        <= '0;
            bcnt_q       <= '0;
            asm_q        <= '0;
            ready_q      <= 1'b0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            core_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            // The write strobe is only ever a single-cycle pulse.
            we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (load_start) begin
                        state_q      <= S_HDR0;
                        ready_q      <= 1'b1;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        err_q        <= 1'b0;
                        core_rst_n_q <= 1'b0;
                    end
                end
                S_HDR0: begin
                    if (xfer) begin
                        n_q[7:0] <= byte_data;
                        state_q  <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (xfer) begin
                        n_q    <= n_d;
                        idx_q  <= '0;
                        bcnt_q <= '0;
                        if (n_d == 16'd0) begin
                            state_q      <= S_DONE;
                            ready_q      <= 1'b0;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                            core_rst_n_q <= 1'b1;
                        end else if ({1'b0, n_d} > CAP) begin
                            state_q <= S_ERR;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        asm_q  <= word_d[31:8];
                        bcnt_q <= bcnt_q + 2'd1;
                        if (bcnt_q == 2'd3) begin
                            // Stop accepting bytes so nothing arrives while the
                            // word is being written.
                            state_q <= S_WRITE;
                            ready_q <= 1'b0;
                            we_q    <= 1'b1;
                            waddr_q <= idx_q[ADDR_W-1:0];
                            wdata_q <= word_d;
                        end
                    end
                end
                S_WRITE: begin
                    idx_q <= idx_d;
                    if (17'(idx_d) == {1'b0, n_q}) begin
                        state_q      <= S_DONE;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        core_rst_n_q <= 1'b1;
                    end else begin
                        state_q <= S_DATA;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign byte_ready = ready_q;
    assign imem_we    = we_q;
    assign imem_waddr = waddr_q;
    assign imem_wdata = wdata_q;
    assign core_rst_n = core_rst_n_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: a table of whole-load scenarios driven through
// a byte-level driver, with expected memory writes queued in a scoreboard
// and compared by a monitor whenever the loader strobes imem_we. Hand-written
// sequences cover reset mid-load and load_start while busy.
module tb_imem_loader;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load_start = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'h00;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              core_rst_n;
    logic              busy;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;
    wr_t sb_q[$];

    typedef struct {
        logic [15:0] n;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] seed;
        bit          gaps;
        bit          exp_err;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input vec_t v, input int i);
        if (i == 0) return v.w0;
        if (i == 1) return v.w1;
        return v.seed ^ (32'(i) * 32'h0100_0193);
    endfunction

    // Scoreboard consumer: every write strobe must match the oldest queued word.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (imem_we === 1'b1) begin
            wr_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                         imem_waddr, imem_wdata);
            end else begin
                e = sb_q.pop_front();
                check("waddr", 32'(imem_waddr), 32'(e.addr));
                check("wdata", imem_wdata, e.data);
            end
        end
    end

    // Called and returns at posedge+1. Holds the byte until a posedge with
    // byte_ready high (sampled on the preceding negedge).
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t;
        bit got;
        if (gaps) begin
            byte_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        byte_valid = 1'b1;
        byte_data  = b;
        t   = 0;
        got = 1'b0;
        while (!got && t < 50) begin
            @(negedge clk);
            if (byte_ready === 1'b1) got = 1'b1;
            else t++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout: byte 0x%0h never accepted, expected acceptance", b);
        end
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    // Sends one word; optionally presents the next byte during the WRITE cycle.
    task automatic send_word(input logic [ADDR_W-1:0] addr, input logic [31:0] w,
                             input bit gaps, input bit has_nxt, input logic [7:0] nxt);
        wr_t e;
        for (int b = 0; b < 4; b++) begin
            if (b == 3) begin
                e.addr = addr;
                e.data = w;
                sb_q.push_back(e);
            end
            send_byte(w[8*b +: 8], gaps);
        end
        if (has_nxt) begin
            byte_valid = 1'b1;
            byte_data  = nxt;
        end
        @(negedge clk);
        check1("we_latency", imem_we, 1'b1);
        check1("ready_in_write", byte_ready, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1;
        load_start = 1'b1;
        @(posedge clk);
        #1;
        load_start = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check1("rst_byte_ready", byte_ready, 1'b0);
        check1("rst_imem_we", imem_we, 1'b0);
        check("rst_imem_waddr", 32'(imem_waddr), 32'h0);
        check("rst_imem_wdata", imem_wdata, 32'h0);
        check1("rst_core_rst_n", core_rst_n, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_err", err, 1'b0);
    endtask

    task automatic run_load(input vec_t v);
        logic [31:0] w;
        logic [31:0] nw;
        logic [15:0] last;
        wr_cnt = 0;
        w = 32'h0;
        pulse_start();
        @(negedge clk);
        check1("start_core_rst_n", core_rst_n, 1'b0);
        check1("start_busy", busy, 1'b1);
        check1("start_done", done, 1'b0);
        check1("start_err", err, 1'b0);
        check1("start_ready", byte_ready, 1'b1);
        @(posedge clk);
        #1;
        send_byte(v.n[7:0], v.gaps);
        send_byte(v.n[15:8], v.gaps);
        if (v.exp_err) begin
            @(negedge clk);
            check1("err_flag", err, 1'b1);
            check1("err_core_rst_n", core_rst_n, 1'b0);
            check1("err_busy", busy, 1'b0);
            check1("err_done", done, 1'b0);
            byte_valid = 1'b1;
            byte_data  = 8'h5A;
            repeat (4) begin
                @(negedge clk);
                check1("err_ready", byte_ready, 1'b0);
            end
            byte_valid = 1'b0;
            check("err_writes", 32'(wr_cnt), 32'h0);
        end else begin
            for (int i = 0; i < int'(v.n); i++) begin
                w  = word_of(v, i);
                nw = word_of(v, i + 1);
                send_word(ADDR_W'(i), w, v.gaps, (i + 1 < int'(v.n)), nw[7:0]);
            end
            @(negedge clk);
            check1("done_flag", done, 1'b1);
            check1("done_core_rst_n", core_rst_n, 1'b1);
            check1("done_busy", busy, 1'b0);
            check1("done_err", err, 1'b0);
            check1("done_ready", byte_ready, 1'b0);
            check("write_count", 32'(wr_cnt), 32'(v.n));
            check("sb_drained", 32'(sb_q.size()), 32'h0);
            if (v.n != 16'd0) begin
                last = v.n - 16'd1;
                check("hold_waddr", 32'(imem_waddr), 32'(last[ADDR_W-1:0]));
                check("hold_wdata", imem_wdata, w);
            end
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin : main
        vec_t v;
        wr_t  e;
        vecs[0] = '{n: 16'd2,   w0: 32'h0010_0013, w1: 32'h0050_0193, seed: 32'h0,         gaps: 1'b0, exp_err: 1'b0};
        vecs[1] = '{n: 16'd0,   w0: 32'h0,         w1: 32'h0,         seed: 32'h0,         gaps: 1'b0, exp_err: 1'b0};
        vecs[2] = '{n: 16'd257, w0: 32'h0,         w1: 32'h0,         seed: 32'h0,         gaps: 1'b0, exp_err: 1'b1};
        vecs[3] = '{n: 16'd3,   w0: 32'h1122_3344, w1: 32'h5566_7788, seed: 32'hA5A5_0000, gaps: 1'b1, exp_err: 1'b0};
        vecs[4] = '{n: 16'd256, w0: 32'hCAFE_0001, w1: 32'hCAFE_0002, seed: 32'h1234_5678, gaps: 1'b0, exp_err: 1'b0};
        vecs[5] = '{n: 16'd1,   w0: 32'hDEAD_BEEF, w1: 32'h0,         seed: 32'h0,         gaps: 1'b1, exp_err: 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int k = 0; k < 6; k++) run_load(vecs[k]);

        // Reset after 6 payload bytes of a 2-word load.
        wr_cnt = 0;
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_word(ADDR_W'(0), 32'h0000_0517, 1'b0, 1'b0, 8'h00);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        v = '{n: 16'd1, w0: 32'h00A0_0093, w1: 32'h0, seed: 32'h0, gaps: 1'b0, exp_err: 1'b0};
        run_load(v);

        // load_start in the middle of a word must be ignored.
        wr_cnt = 0;
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hEF, 1'b0);
        send_byte(8'hBE, 1'b0);
        load_start = 1'b1;
        @(posedge clk);
        #1;
        load_start = 1'b0;
        e.addr = ADDR_W'(0);
        e.data = 32'h0BAD_BEEF;
        sb_q.push_back(e);
        send_byte(8'hAD, 1'b0);
        send_byte(8'h0B, 1'b0);
        @(negedge clk);
        check1("busy_we", imem_we, 1'b1);
        @(posedge clk);
        #1;
        send_word(ADDR_W'(1), 32'h7654_3210, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        check1("busy_done", done, 1'b1);
        check("busy_writes", 32'(wr_cnt), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
